// File: rtl/counter_arbiter_pkg.sv
// rtl/counter_arbiter_pkg.sv - shared types, widths and step arithmetic for counter_arbiter
package counter_arbiter_pkg;

  localparam int CNT_W  = 2;
  localparam int STEP_W = 2;

  localparam logic [1:0] MODE_UP4 = 2'd0;
  localparam logic [1:0] MODE_DN4 = 2'd1;
  localparam logic [1:0] MODE_UP3 = 2'd2;
  localparam logic [1:0] MODE_DN3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The *3 modes count over 0..2 only; an out-of-range 3 falls back into that range.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic [1:0]       mode);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    case (mode)
      MODE_UP4: nxt = cur + 2'd1;
      MODE_DN4: nxt = cur - 2'd1;
      MODE_UP3: nxt = (cur == 2'd2 || cur == 2'd3) ? 2'd0 : cur + 2'd1;
      MODE_DN3: nxt = (cur == 2'd0) ? 2'd2 : ((cur == 2'd3) ? 2'd2 : cur - 2'd1);
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/counter_arbiter_count_core.sv
// rtl/counter_arbiter_count_core.sv - 2-bit count register stepped by the arbiter FSM
module count_core
  import counter_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             step_en,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step_en) cnt_d = next_count(cnt_q, mode);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - two-requester round-robin arbiter driving a shared step counter
module counter_arbiter
  import counter_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        mode0,
  input  logic [1:0]        mode1,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              step_en,
  output logic [1:0]        mode,
  output logic              done,
  output logic [CNT_W-1:0]  q
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic [1:0]        lmode_q, lmode_d;
  logic [STEP_W-1:0] lsteps_q, lsteps_d;
  logic [STEP_W-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    lmode_d   = lmode_q;
    lsteps_d  = lsteps_q;
    run_cnt_d = run_cnt_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    step_en   = 1'b0;
    mode      = 2'd0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Winner is chosen at the sampling edge; the pointer only breaks ties.
        if (req0 || req1) begin
          state_d = ST_GRANT;
          win_d   = (req0 && req1) ? ptr_q : req1;
        end
      end
      ST_GRANT: begin
        gnt0      = ~win_q;
        gnt1      = win_q;
        lmode_d   = win_q ? mode1 : mode0;
        lsteps_d  = win_q ? steps1 : steps0;
        run_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        step_en = 1'b1;
        mode    = lmode_q;
        if (run_cnt_q == lsteps_q) state_d = ST_DONE;
        else                       run_cnt_d = run_cnt_q + 2'd1;
      end
      ST_DONE: begin
        done    = 1'b1;
        ptr_d   = ~win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      win_q     <= 1'b0;
      lmode_q   <= '0;
      lsteps_q  <= '0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      lmode_q   <= lmode_d;
      lsteps_q  <= lsteps_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  count_core u_count_core (
    .clock   (clock),
    .reset   (reset),
    .step_en (step_en),
    .mode    (mode),
    .q       (q)
  );

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed self-checking bench for counter_arbiter
module tb_counter_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] mode0, mode1, steps0, steps1;
  logic       gnt0, gnt1, busy, step_en, done;
  logic [1:0] mode, q;

  int total = 0;
  int bad   = 0;
  int ndone;

  always #5 clock = ~clock;

  counter_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .mode0   (mode0),
    .mode1   (mode1),
    .steps0  (steps0),
    .steps1  (steps1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .step_en (step_en),
    .mode    (mode),
    .done    (done),
    .q       (q)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit k, input logic [1:0] m, input logic [1:0] s,
                     input logic [1:0] q_exp, input string tag);
    if (!k) begin req0 = 1'b1; mode0 = m; steps0 = s; end
    else    begin req1 = 1'b1; mode1 = m; steps1 = s; end
    tick();
    chk({tag, "_gnt0"}, gnt0, !k);
    chk({tag, "_gnt1"}, gnt1, k);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i <= int'(s); i++) begin
      tick();
      chk({tag, "_step_en"}, step_en, 1'b1);
    end
    tick();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_q"}, q, q_exp);
    tick();
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    mode0 = 2'd0; mode1 = 2'd0; steps0 = 2'd0; steps1 = 2'd0;
    tick(); tick();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_en", step_en, 0);
    chk("rst_mode", mode, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    reset = 1'b0;

    // up-count, 3 steps
    req0 = 1'b1; mode0 = 2'd0; steps0 = 2'd2;
    tick();
    chk("s1_gnt0", gnt0, 1); chk("s1_gnt1", gnt1, 0);
    chk("s1_busy", busy, 1); chk("s1_grant_step", step_en, 0);
    req0 = 1'b0;
    tick(); chk("s1_r1_en", step_en, 1); chk("s1_r1_mode", mode, 0); chk("s1_r1_q", q, 0);
    tick(); chk("s1_r2_en", step_en, 1); chk("s1_r2_q", q, 1);
    tick(); chk("s1_r3_en", step_en, 1); chk("s1_r3_q", q, 2);
    tick(); chk("s1_done", done, 1); chk("s1_done_en", step_en, 0); chk("s1_done_q", q, 3);
    tick(); chk("s1_idle_done", done, 0); chk("s1_idle_busy", busy, 0); chk("s1_hold_q", q, 3);

    // round-robin
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s2_rst_q", q, 0);
    req0 = 1'b1; req1 = 1'b1; mode0 = 2'd0; steps0 = 2'd0; mode1 = 2'd1; steps1 = 2'd0;
    tick(); chk("s2a_gnt0", gnt0, 1); chk("s2a_gnt1", gnt1, 0);
    req0 = 1'b0;
    tick(); chk("s2a_run_q", q, 0);
    tick(); chk("s2a_done", done, 1); chk("s2a_q", q, 1); chk("s2a_nogn1", gnt1, 0);
    tick(); chk("s2a_idle", busy, 0); chk("s2a_idle_gnt1", gnt1, 0);
    tick(); chk("s2b_gnt1", gnt1, 1); chk("s2b_gnt0", gnt0, 0);
    req1 = 1'b0;
    tick(); chk("s2b_mode", mode, 1); chk("s2b_q", q, 1);
    tick(); chk("s2b_done", done, 1); chk("s2b_q_end", q, 0);
    tick(); chk("s2b_idle", busy, 0);
    req0 = 1'b1; req1 = 1'b1;
    tick(); chk("s2c_gnt0", gnt0, 1); chk("s2c_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick(); chk("s2c_done", done, 1); chk("s2c_q", q, 1);
    tick();

    // mod-3 modes
    txn(1'b0, 2'd0, 2'd0, 2'd2, "s3_setq2");
    req0 = 1'b1; mode0 = 2'd2; steps0 = 2'd1;
    tick(); chk("s3a_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick(); chk("s3a_mode", mode, 2); chk("s3a_q0", q, 2);
    tick(); chk("s3a_q1", q, 0);
    tick(); chk("s3a_done", done, 1); chk("s3a_q2", q, 1);
    tick();
    txn(1'b1, 2'd1, 2'd0, 2'd0, "s3_setq0");
    req0 = 1'b1; mode0 = 2'd3; steps0 = 2'd0;
    tick(); chk("s3b_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick(); chk("s3b_mode", mode, 3); chk("s3b_q0", q, 0);
    tick(); chk("s3b_done", done, 1); chk("s3b_q", q, 2);
    tick(); chk("s3b_idle_mode", mode, 0);

    // down-count, 4 steps, only req1 after reset
    reset = 1'b1; tick(); reset = 1'b0;
    req1 = 1'b1; mode1 = 2'd1; steps1 = 2'd3;
    tick(); chk("s4_gnt1", gnt1, 1); chk("s4_gnt0", gnt0, 0);
    req1 = 1'b0;
    ndone = 0;
    tick(); ndone += int'(done); chk("s4_q0", q, 0);
    tick(); ndone += int'(done); chk("s4_q1", q, 3);
    tick(); ndone += int'(done); chk("s4_q2", q, 2);
    tick(); ndone += int'(done); chk("s4_q3", q, 1);
    tick(); ndone += int'(done); chk("s4_q4", q, 0);
    tick(); ndone += int'(done);
    chk("s4_done_count", ndone[3:0], 1);

    // reset mid-RUN
    req0 = 1'b1; mode0 = 2'd0; steps0 = 2'd3;
    tick(); chk("s5_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick(); chk("s5_r1_q", q, 0);
    tick(); chk("s5_r2_en", step_en, 1); chk("s5_r2_q", q, 1);
    reset = 1'b1; req0 = 1'b1;
    tick();
    chk("s5_q", q, 0); chk("s5_busy", busy, 0); chk("s5_done", done, 0);
    chk("s5_en", step_en, 0); chk("s5_mode", mode, 0); chk("s5_gnt0", gnt0, 0);
    reset = 1'b0; req0 = 1'b0;
    tick(); chk("s5_after_done", done, 0); chk("s5_after_busy", busy, 0);

    // req1 pulsed while busy
    req0 = 1'b1; mode0 = 2'd0; steps0 = 2'd1;
    tick(); chk("s6_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick(); chk("s6_r1_q", q, 0);
    req1 = 1'b1;
    tick(); chk("s6_r2_gnt1", gnt1, 0); chk("s6_r2_q", q, 1);
    req1 = 1'b0;
    tick(); chk("s6_done", done, 1); chk("s6_done_gnt1", gnt1, 0); chk("s6_q", q, 2);
    tick(); chk("s6_idle_gnt1", gnt1, 0); chk("s6_idle_busy", busy, 0);
    tick(); chk("s6_idle2_gnt1", gnt1, 0); chk("s6_idle2_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be synchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req0, req1  in  1 each  requester k wants a counting transaction; held high until grant.
- mode0, mode1  in  2 each  requested mode {s1,s0}, sampled at grant.
- steps0, steps1  in  2 each  step count minus one (0..3 = 1..4 steps), sampled at grant.
- gnt0, gnt1  out  1 each  one-cycle grant pulse to requester k.
- busy  out  1  transaction in progress (GRANT, RUN or DONE).
- step_en  out  1  counter advances at the end of this cycle.
- mode  out  2  mode currently applied, {s1,s0}.
- done  out  1  one-cycle completion pulse.
- q  out  2  current count value.

Function
REQ-003 The FSM SHALL have the states IDLE, GRANT, RUN and DONE.
REQ-004 IDLE: when any req is high at a rising edge, the FSM SHALL go to GRANT; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin between the two requesters.
- A priority pointer SHALL point at requester 0 after reset.
- After requester k is served, the pointer SHALL point at the other requester.
- If only one req is high, that requester SHALL win regardless of the pointer.
REQ-006 GRANT lasts one cycle.
- gnt of the winner SHALL be high; the other gnt SHALL be low.
- The winner's mode and steps SHALL be latched at the end of this cycle.
- The next state SHALL be RUN.
REQ-007 RUN SHALL last exactly steps+1 cycles.
- step_en SHALL be 1 and mode SHALL equal the latched mode.
- q SHALL update once per RUN cycle.
- After the last step the next state SHALL be DONE.
REQ-008 DONE lasts one cycle: done SHALL be 1, the pointer SHALL update, and the next state SHALL be IDLE.
REQ-009 Step arithmetic (mod 4 on 2 bits), per mode:
- Mode 0: q+1, so 3 wraps to 0.
- Mode 1: q-1, so 0 wraps to 3.
- Mode 2: if q==2 then 0, else q+1 (3 goes to 0).
- Mode 3: if q==0 then 2, else q-1 (3 goes to 2).
REQ-010 q SHALL hold its value when step_en is 0, and SHALL persist across transactions.
REQ-011 A req that falls before its grant SHALL be dropped; no state SHALL be retained for it.
REQ-012 Requests arriving while busy SHALL be ignored until the FSM returns to IDLE.
- Minimum request-to-request spacing SHALL be 1 IDLE cycle.
REQ-013 busy SHALL be 1 in GRANT, RUN and DONE, and 0 in IDLE.
REQ-014 A transaction's minimum total latency SHALL be 4 cycles for steps=0, from the req-sampling edge to done high (inclusive of the IDLE sample).
REQ-015 The mode output SHALL be 0 whenever step_en is 0.

Reset
REQ-016 When reset is high at a rising edge, the block SHALL do the following, regardless of state, including mid-RUN:
- The FSM SHALL go to IDLE.
- q SHALL be 0 and the pointer SHALL be 0.
- gnt0, gnt1, busy, step_en, done and mode SHALL all be 0.
- The latched mode and steps SHALL be cleared.
REQ-017 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-018 A shared package SHALL hold:
- the FSM state enum;
- the mode encodings MODE_UP4=0, MODE_DN4=1, MODE_UP3=2, MODE_DN3=3;
- the width constants CNT_W=2 and STEP_W=2.
REQ-019 The counter datapath (REQ-009 and REQ-010) SHALL be a sub-module named count_core.
- Inputs: clock, reset, step_en, mode.
- Output: q.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- After reset, req0=1, mode0=0, steps0=2 -> gnt0 one cycle later, then 3 step_en cycles, q=3, then done=1.
- req0 and req1 high together from the post-reset pointer -> gnt0 first; req1 held -> gnt1 next transaction; repeat both -> gnt0.
- q=2, mode 2, steps=1 -> q goes 0 then 1; then q=0, mode 3, steps=0 -> q=2.
- q=0, mode 1, steps=3 -> q goes 3, 2, 1, 0; done pulses once.
- reset asserted on the 2nd RUN cycle of a 4-step transaction -> next cycle q=0, busy=0, no done pulse.
- req1 pulsed while busy and dropped before IDLE -> no gnt1 issued.
